// File: rtl/maj_tt_sweeper.sv
// ----------------------------------------------------------------------------
// maj_tt_sweeper
//
// Characterises a small network of three-input majority nodes by sweeping all
// 128 assignments of x0..x6 and assembling the resulting 128-bit truth table.
// A single shared MAJ3 evaluator is time-multiplexed over the node program,
// one node per cycle, so each input pattern costs exactly n cycles.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   prog_we    program slot write strobe (ignored unless idle)
//   prog_addr  program slot to write
//   prog_data  {op2, op1, op0}, 4 bits each
//   n_nodes    node count, sampled together with start
//   start      begin a sweep (ignored unless idle)
//   busy       sweep in progress
//   done       one-cycle pulse once tt is final
//   err        one-cycle pulse after a start with an illegal node count
//   tt         truth table, tt[p] = f(x0..x6 = p), x0 = LSB of p
//
// Operand encoding: 0..6 -> x0..x6, 7 -> constant 0, 8..15 -> node (sel-8).
// A node operand that points at itself or a later node reads 0.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; program writes accepted
// EVAL   | evaluating node k of pattern p, one node per cycle
// DONE   | done pulse for one cycle, then back to IDLE
// ----------------------------------------------------------------------------
module maj_tt_sweeper #(
  parameter int MAX_NODES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         prog_we,
  input  logic [2:0]   prog_addr,
  input  logic [11:0]  prog_data,
  input  logic [3:0]   n_nodes,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] tt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0]  MAX_N4    = 4'(MAX_NODES);
  localparam logic [11:0] PROG_ZERO = {4'd7, 4'd7, 4'd7};

  state_t                 state_q, state_d;
  logic [3:0]             n_q, n_d;
  logic [6:0]             p_q, p_d;
  logic [2:0]             k_q, k_d;
  logic [MAX_NODES-1:0]   node_q, node_d;
  logic [127:0]           tt_q, tt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [11:0]            prog_q [MAX_NODES];
  logic [11:0]            prog_d [MAX_NODES];

  logic [11:0]            cur_prog;
  logic [7:0]             res8;
  logic                   a_val, b_val, c_val;
  logic                   maj_out;
  logic                   last_node;
  logic                   start_ok;
  logic                   addr_ok;

  // Resolve one 4-bit operand against the current pattern and the node
  // results produced so far for this pattern. The j < k guard keeps self and
  // forward references at 0 regardless of what the result register holds.
  function automatic logic op_val(input logic [3:0] sel,
                                  input logic [6:0] pat,
                                  input logic [7:0] res,
                                  input logic [2:0] k);
    logic v;
    v = 1'b0;
    if (sel < 4'd7) begin
      v = pat[sel[2:0]];
    end else if (sel[3] && (sel[2:0] < k)) begin
      v = res[sel[2:0]];
    end
    return v;
  endfunction

  // Shared evaluator datapath
  always_comb begin
    cur_prog  = prog_q[k_q];
    res8      = 8'(node_q);
    a_val     = op_val(cur_prog[3:0],  p_q, res8, k_q);
    b_val     = op_val(cur_prog[7:4],  p_q, res8, k_q);
    c_val     = op_val(cur_prog[11:8], p_q, res8, k_q);
    maj_out   = (a_val & b_val) | (a_val & c_val) | (b_val & c_val);
    last_node = ({1'b0, k_q} == (n_q - 4'd1));
    start_ok  = (n_nodes != 4'd0) && (n_nodes <= MAX_N4);
    addr_ok   = ({1'b0, prog_addr} < MAX_N4);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    p_d     = p_q;
    k_d     = k_q;
    node_d  = node_q;
    tt_d    = tt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    prog_d  = prog_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // The write and a same-cycle start both commit on this edge; the
        // sweep first reads the program a cycle later, so the write wins.
        if (prog_we && addr_ok) begin
          prog_d[prog_addr] = prog_data;
        end
        if (start) begin
          if (start_ok) begin
            state_d = S_EVAL;
            n_d     = n_nodes;
            p_d     = 7'd0;
            k_d     = 3'd0;
            node_d  = '0;
            tt_d    = '0;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_EVAL: begin
        busy_d         = 1'b1;
        node_d[k_q]    = maj_out;
        if (last_node) begin
          tt_d[p_q] = maj_out;
          if (p_q == 7'd127) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            p_d    = p_q + 7'd1;
            k_d    = 3'd0;
            node_d = '0;
          end
        end else begin
          k_d = k_q + 3'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= 4'd0;
      p_q     <= 7'd0;
      k_q     <= 3'd0;
      node_q  <= '0;
      tt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < MAX_NODES; i++) begin
        prog_q[i] <= PROG_ZERO;
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      p_q     <= p_d;
      k_q     <= k_d;
      node_q  <= node_d;
      tt_q    <= tt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      prog_q  <= prog_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign tt   = tt_q;

endmodule

// File: tb/tb_maj_tt_sweeper.sv
module tb_maj_tt_sweeper;

  logic         clk = 1'b0;
  logic         rst;
  logic         prog_we;
  logic [2:0]   prog_addr;
  logic [11:0]  prog_data;
  logic [3:0]   n_nodes;
  logic         start;
  logic         busy;
  logic         done;
  logic         err;
  logic [127:0] tt;

  always #5 clk = ~clk;

  maj_tt_sweeper #(.MAX_NODES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .n_nodes   (n_nodes),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .tt        (tt)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string        name;
    logic [127:0] tt;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [11:0]  prog_m [8];
  logic [127:0] last_tt;

  localparam logic [127:0] TT_SIX = 128'hfeeaece8eee8e8e0f8e8e888e8c8a880;
  localparam logic [127:0] TT_E8  = {16{8'he8}};
  localparam logic [127:0] TT_88  = {16{8'h88}};

  // Independent reference: evaluate the node program pattern by pattern.
  function automatic logic [127:0] model_tt(input int n);
    logic [127:0] r;
    logic [7:0]   res;
    logic [3:0]   s;
    logic [2:0]   v;
    int           j;
    r = '0;
    for (int p = 0; p < 128; p++) begin
      res = '0;
      for (int k = 0; k < n; k++) begin
        for (int o = 0; o < 3; o++) begin
          s = prog_m[k][4*o +: 4];
          if (s < 4'd7) v[o] = ((p >> s) & 1) != 0;
          else if (s == 4'd7) v[o] = 1'b0;
          else begin
            j = int'(s) - 8;
            v[o] = (j < k) ? res[j] : 1'b0;
          end
        end
        res[k] = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
      end
      r[p] = res[n-1];
    end
    return r;
  endfunction

  task automatic write_slot(input logic [2:0] a, input logic [3:0] o0,
                            input logic [3:0] o1, input logic [3:0] o2);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = {o2, o1, o0};
    @(posedge clk); #1;
    prog_we   = 1'b0;
    prog_m[a] = {o2, o1, o0};
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) prog_m[i] = 12'h777;
  endtask

  // Start a sweep, optionally disturb it in cycle 'disturb', wait for done
  // and compare against the scoreboard entry pushed here.
  task automatic run_sweep(input string name, input int n,
                           input logic [127:0] exp_tt, input int disturb);
    int    cyc;
    bit    got;
    bit    err_seen;
    exp_t  e;
    sb.push_back('{name, exp_tt, 128*n + 1});
    start   = 1'b1;
    n_nodes = 4'(n);
    @(posedge clk); #1;
    start   = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL %s busy_cycle1 got=%b exp=1", name, busy);
    else n_pass++;
    cyc = 1; got = 0; err_seen = 0;
    while (cyc <= 128*n + 20) begin
      if (done === 1'b1) begin got = 1; break; end
      if (err === 1'b1) err_seen = 1;
      if (cyc == disturb) begin
        start = 1'b1; n_nodes = 4'd3;
        prog_we = 1'b1; prog_addr = 3'd0; prog_data = 12'h210;
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; prog_we = 1'b0;
    e = sb.pop_front();
    n_total++;
    if (!got) begin
      $display("FAIL %s done_timeout got=none exp=cycle %0d", e.name, e.cyc);
    end else if (cyc != e.cyc) begin
      $display("FAIL %s done_cycle got=%0d exp=%0d", e.name, cyc, e.cyc);
    end else n_pass++;
    n_total++;
    if (tt !== e.tt) $display("FAIL %s tt got=%h exp=%h", e.name, tt, e.tt);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || err_seen) $display("FAIL %s busy_err_at_done got=%b/%b exp=0/0", e.name, busy, err_seen);
    else n_pass++;
    last_tt = e.tt;
    @(posedge clk); #1;
    n_total++;
    if (done !== 1'b0) $display("FAIL %s done_width got=%b exp=0", e.name, done);
    else n_pass++;
  endtask

  task automatic load_six();
    write_slot(3'd0, 4'd1, 4'd4, 4'd5);
    write_slot(3'd1, 4'd0, 4'd2, 4'd4);
    write_slot(3'd2, 4'd1, 4'd3, 4'd9);
    write_slot(3'd3, 4'd0, 4'd1, 4'd6);
    write_slot(3'd4, 4'd0, 4'd8, 4'd10);
    write_slot(3'd5, 4'd2, 4'd11, 4'd12);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; n_nodes = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    last_tt = '0;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_flags got=%b%b%b exp=000", busy, done, err);
    else n_pass++;
    n_total++;
    if (tt !== '0) $display("FAIL reset_tt got=%h exp=0", tt);
    else n_pass++;
  endtask

  task automatic test_six_node();
    load_six();
    n_total++;
    if (model_tt(6) !== TT_SIX) $display("FAIL model_six got=%h exp=%h", model_tt(6), TT_SIX);
    else n_pass++;
    run_sweep("six_node", 6, TT_SIX, 0);
  endtask

  task automatic test_single_node();
    write_slot(3'd0, 4'd0, 4'd1, 4'd2);
    run_sweep("single_maj", 1, TT_E8, 0);
    write_slot(3'd0, 4'd0, 4'd1, 4'd7);
    run_sweep("single_and", 1, TT_88, 0);
  endtask

  task automatic test_forward_ref();
    write_slot(3'd0, 4'd0, 4'd1, 4'd9);
    write_slot(3'd1, 4'd8, 4'd8, 4'd2);
    run_sweep("forward_ref", 2, TT_88, 0);
  endtask

  task automatic test_bad_start(input logic [3:0] n);
    start = 1'b1; n_nodes = n;
    @(posedge clk); #1;
    start = 1'b0;
    n_total++;
    if (err !== 1'b1 || busy !== 1'b0)
      $display("FAIL bad_start_%0d err/busy got=%b/%b exp=1/0", n, err, busy);
    else n_pass++;
    n_total++;
    if (tt !== last_tt) $display("FAIL bad_start_%0d tt got=%h exp=%h", n, tt, last_tt);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL bad_start_%0d after got=%b%b%b exp=000", n, err, busy, done);
    else n_pass++;
  endtask

  task automatic test_ignore_while_busy();
    load_six();
    run_sweep("disturbed", 6, TT_SIX, 200);
    run_sweep("after_disturb", 6, TT_SIX, 0);
  endtask

  task automatic test_write_with_start();
    prog_we = 1'b1; prog_addr = 3'd0; prog_data = {4'd2, 4'd1, 4'd0};
    prog_m[0] = {4'd2, 4'd1, 4'd0};
    run_sweep("write_with_start", 1, TT_E8, 0);
  endtask

  task automatic test_random(input int iters);
    int n;
    for (int it = 0; it < iters; it++) begin
      n = (it == 0) ? 8 : int'($urandom_range(1, 8));
      for (int s = 0; s < n; s++)
        write_slot(3'(s), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)));
      run_sweep($sformatf("random_%0d", it), n, model_tt(n), 0);
    end
  endtask

  task automatic test_reset_mid();
    int  cyc;
    bit  done_seen;
    load_six();
    start = 1'b1; n_nodes = 4'd6;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 300) begin @(posedge clk); #1; cyc++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || tt !== '0)
      $display("FAIL reset_mid got=busy%b done%b err%b tt=%h exp=0", busy, done, err, tt);
    else n_pass++;
    done_seen = 0;
    repeat (600) begin @(posedge clk); #1; if (done === 1'b1) done_seen = 1; end
    n_total++;
    if (done_seen) $display("FAIL reset_mid_no_done got=1 exp=0");
    else n_pass++;
    run_sweep("rerun_cleared", 6, '0, 0);
  endtask

  initial begin
    test_reset();
    test_six_node();
    test_single_node();
    test_forward_ref();
    test_bad_start(4'd0);
    test_bad_start(4'd9);
    test_ignore_while_busy();
    test_write_with_start();
    test_random(3);
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/maj_tt_sweeper.md
# maj_tt_sweeper

Controller that characterises a majority-gate (MAJ3) network by sweeping all 128 assignments of seven inputs x0..x6 and assembling the 128-bit truth table. It holds a small node program of up to MAX_NODES three-input majority nodes and time-multiplexes a single shared MAJ3 evaluator over those nodes, one node per cycle, for each input pattern. It sits in front of the classification flow and produces the truth-table word used to name and bin each 7-input function.

## Interface
- MAX_NODES, 8, number of program slots; legal range 1..8 (the operand field addresses at most 8 nodes)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- prog_we  in  1  program write strobe; ignored while busy
- prog_addr  in  3  node slot written (must be < MAX_NODES, else write ignored)
- prog_data  in  12  operands {op2[11:8], op1[7:4], op0[3:0]}
- n_nodes  in  4  node count, sampled with start
- start  in  1  begin sweep; ignored while busy
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when tt is final
- err  out  1  one-cycle pulse on rejected start
- tt  out  128  truth table; tt[p] = f(x0..x6 = p), x0 = LSB of p

## Operation
- Operand encoding (4 bits): 0..6 select x0..x6 (bits of current pattern p); 7 = constant 0; 8..15 select stored result of node (sel-8).
- Node k computes maj(op0,op1,op2) = (a&b)|(a&c)|(b&c). Function output = node n_nodes-1.
- Operand referencing node j >= k (self or forward) reads 0, never a stale value. Node j >= n_nodes reads 0.
- States: IDLE, EVAL, DONE.
- IDLE: start with 1 <= n_nodes <= MAX_NODES -> latch n, p=0, k=0, clear node results, go EVAL. Start with n_nodes = 0 or > MAX_NODES -> err pulse next cycle, stay IDLE, tt unchanged.
- EVAL: each cycle evaluate node k, store result. If k < n-1: k++. If k == n-1: write tt[p]; if p == 127 go DONE, else p++, k=0, clear node results.
- DONE: done=1, busy=0 for one cycle, return IDLE. tt holds until next accepted start.
- Accepted start clears tt to 0 on entering EVAL; bits fill in ascending p.
- prog_we and start while busy: ignored, no side effect. Program writes in IDLE take effect for the next sweep, including a write in the same cycle as start (write lands first).
- Program memory is not modified by a sweep.

## Timing
- Reset: busy=0, done=0, err=0, tt=0, state IDLE, all program slots = {7,7,7} (constant 0).
- Start sampled in cycle 0 -> busy=1 from cycle 1; evaluations occupy cycles 1..128*n; done=1 and busy=0 in cycle 128*n+1.
- Throughput: exactly n cycles per pattern, no bubbles.
- err asserted in cycle 1 after a rejected start, for one cycle.
- rst mid-sweep: next cycle all outputs at reset values, program cleared; no done pulse.
- done and err never asserted together; done never asserted without a preceding accepted start.

## Test plan
- Load 6-node program {1,4,5},{0,2,4},{1,3,9},{0,1,6},{0,8,10},{2,11,12} (op0,op1,op2), n=6, start -> done in cycle 769, tt = 128'hfeeaece8eee8e8e0f8e8e888e8c8a880.
- Single node {0,1,2}, n=1 -> done in cycle 129, tt = 0xe8 repeated 16 times; then node {0,1,7} -> tt = 0x88 repeated.
- Forward reference: node0 {0,1,9}, node1 {8,8,2}, n=2 -> tt = 0x88 repeated (node1 read as 0 by node0), done in cycle 257.
- Start with n_nodes=0 and with n_nodes=9 -> err pulse in cycle 1 each, busy stays 0, tt unchanged.
- During sweep: pulse start and prog_we -> ignored, final tt and done timing identical to undisturbed run.
- Assert rst at cycle 300 of a 6-node sweep -> next cycle busy=0, tt=0, done never pulses; rerun without reloading gives tt=0 (program cleared).
